// File: rtl/output_readback_if.sv
// Output-RAM read port plus downstream valid/ready stream for output_readback.
// master = the readback engine, slave = RAM model / consumer side.
interface output_readback_if #(
   parameter int unsigned OUTPUT_BITWIDTH = 32,
   parameter int unsigned MAC_COL         = 16,
   parameter int unsigned OUTPUT_ADDR_BIT = 10
);
   logic [OUTPUT_ADDR_BIT-1:0]         ram_addr_out;
   logic                               ram_read_en_out;
   logic [OUTPUT_BITWIDTH*MAC_COL-1:0] ram_rdata_in;
   logic [OUTPUT_BITWIDTH*MAC_COL-1:0] data_out;
   logic                               valid_out;
   logic                               ready_in;
   logic                               last_out;

   modport master (
      output ram_addr_out,
      output ram_read_en_out,
      input  ram_rdata_in,
      output data_out,
      output valid_out,
      input  ready_in,
      output last_out
   );

   modport slave (
      input  ram_addr_out,
      input  ram_read_en_out,
      output ram_rdata_in,
      input  data_out,
      input  valid_out,
      output ready_in,
      input  last_out
   );
endinterface

// File: rtl/output_readback.sv
// Streams OUTPUT_DATA_NUM output-RAM words to a valid/ready consumer via a 2-entry FIFO.
// Optional macro OUTPUT_READBACK_RELU_EN: per-lane ReLU applied at the FIFO output.
module output_readback #(
   parameter int unsigned OUTPUT_BITWIDTH = 32,
   parameter int unsigned MAC_COL         = 16,
   parameter int unsigned OUTPUT_ADDR_BIT = 10,
   parameter int unsigned OUTPUT_DATA_NUM = 784
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_in,
   output_readback_if.master     bus,
   output logic                  busy_out,
   output logic                  done_out
);
   localparam int unsigned W  = OUTPUT_BITWIDTH * MAC_COL;
   localparam int unsigned CW = $clog2(OUTPUT_DATA_NUM + 1);
   localparam logic [CW-1:0] LAST_IDX = CW'(OUTPUT_DATA_NUM - 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] addr_q;
   logic [CW-1:0] sent_q;
   logic          inflight_q;
   logic [W-1:0]  fifo_q [2];
   logic          wr_ptr_q, rd_ptr_q;
   logic [1:0]    count_q;
   logic [2:0]    occ;
   logic          rd_en, push, pop, last_rd, valid;
   logic [W-1:0]  head;

   always_comb begin
      valid   = (count_q != 2'd0);
      push    = inflight_q;
      pop     = valid & bus.ready_in;
      occ     = {1'b0, count_q} + {2'b00, inflight_q};
      // A same-cycle pop frees a slot before the new read's data lands, which is what
      // sustains one word per cycle; a full FIFO never gets a read regardless.
      rd_en   = (state_q == READ) && (count_q != 2'd2) && (occ < (3'd2 + {2'b00, pop}));
      last_rd = rd_en && (addr_q == LAST_IDX);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_in) state_d = READ;
         READ:    if (last_rd) state_d = DRAIN;
         DRAIN:   if (pop && (sent_q == LAST_IDX)) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
         fifo_q[0]  <= '0;
         fifo_q[1]  <= '0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         inflight_q <= rd_en;
         if (state_q == DONE) begin
            addr_q <= '0;
         end else if (rd_en && !last_rd) begin
            addr_q <= addr_q + CW'(1);
         end
         if (state_q == DONE) begin
            sent_q <= '0;
         end else if (pop) begin
            sent_q <= sent_q + CW'(1);
         end
         if (push) begin
            fifo_q[wr_ptr_q] <= bus.ram_rdata_in;
            wr_ptr_q         <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head = fifo_q[rd_ptr_q];

   always_comb begin
`ifdef OUTPUT_READBACK_RELU_EN
      bus.data_out = head;
      for (int k = 0; k < int'(MAC_COL); k++) begin
         if (head[k*OUTPUT_BITWIDTH + OUTPUT_BITWIDTH - 1]) begin
            bus.data_out[k*OUTPUT_BITWIDTH +: OUTPUT_BITWIDTH] = '0;
         end
      end
`else
      bus.data_out = head;
`endif
   end

   assign bus.ram_addr_out    = OUTPUT_ADDR_BIT'(addr_q);
   assign bus.ram_read_en_out = rd_en;
   assign bus.valid_out       = valid;
   assign bus.last_out        = valid && (sent_q == LAST_IDX);
   assign busy_out            = (state_q == READ) || (state_q == DRAIN);
   assign done_out            = (state_q == DONE);
endmodule

// File: tb/tb_output_readback.sv
// Scoreboard bench for output_readback: an N=784 instance for streaming/back-pressure/reset
// and an N=1 instance for the single-word and per-lane ReLU cases.
module tb_output_readback;
   localparam int BW   = 32;
   localparam int COLS = 16;
   localparam int AB   = 10;
   localparam int N    = 784;
   localparam int W    = BW * COLS;

   typedef struct packed {
      logic [W-1:0] d;
      logic         l;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic start1 = 1'b0;
   logic busy, done, busy1, done1;
   logic [W-1:0] pat1;

   always #5 clk = ~clk;

   output_readback_if #(.OUTPUT_BITWIDTH(BW), .MAC_COL(COLS), .OUTPUT_ADDR_BIT(AB)) bus ();
   output_readback_if #(.OUTPUT_BITWIDTH(BW), .MAC_COL(COLS), .OUTPUT_ADDR_BIT(AB)) bus1 ();

   output_readback #(
      .OUTPUT_BITWIDTH(BW), .MAC_COL(COLS), .OUTPUT_ADDR_BIT(AB), .OUTPUT_DATA_NUM(N)
   ) dut (
      .clk(clk), .rst(rst), .start_in(start), .bus(bus), .busy_out(busy), .done_out(done)
   );

   output_readback #(
      .OUTPUT_BITWIDTH(BW), .MAC_COL(COLS), .OUTPUT_ADDR_BIT(AB), .OUTPUT_DATA_NUM(1)
   ) dut1 (
      .clk(clk), .rst(rst), .start_in(start1), .bus(bus1), .busy_out(busy1), .done_out(done1)
   );

   // RAM models: RAM[i] = i in every lane; the N=1 RAM returns pat1.
   always @(posedge clk) begin
      if (bus.ram_read_en_out) bus.ram_rdata_in <= {COLS{{22'd0, bus.ram_addr_out}}};
      if (bus1.ram_read_en_out) bus1.ram_rdata_in <= pat1;
   end

   int n_vec = 0;
   int n_err = 0;
   exp_t q[$];
   exp_t q1[$];
   int cyc = 0, acc_cnt = 0, first_acc_cyc = 0, last_acc_cyc = 0, done_cnt = 0;
   int rd_idx = 0, nbuf = 0, done1_cnt = 0;
   int rdy_mode = 0;
   logic prev_rd = 1'b0;
   logic stall_q = 1'b0;
   logic [W-1:0] stall_d;

   function automatic void check(input string name, input logic [W-1:0] got,
                                 input logic [W-1:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   initial begin
      bus.ready_in = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.ready_in = 1'b0;
            1:       bus.ready_in = 1'b1;
            default: bus.ready_in = ($urandom_range(0, 9) < 3);
         endcase
      end
   end

   // Monitor for the N=784 instance.
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         nbuf    = 0;
         prev_rd = 1'b0;
         stall_q = 1'b0;
      end else begin
         if (bus.ram_read_en_out) begin
            check("rd_addr", bus.ram_addr_out, rd_idx);
            check("rd_space", nbuf < 2, 1);
            rd_idx++;
         end
         check("valid_vs_buf", bus.valid_out, nbuf != 0);
         if (stall_q) begin
            check("stall_valid", bus.valid_out, 1);
            check("stall_data", bus.data_out, stall_d);
         end
         if (bus.valid_out && bus.ready_in) begin
            check("q_nonempty", q.size() != 0, 1);
            if (q.size() != 0) begin
               e = q.pop_front();
               check("data", bus.data_out, e.d);
               check("last", bus.last_out, e.l);
            end
            if (acc_cnt == 0) first_acc_cyc = cyc;
            last_acc_cyc = cyc;
            acc_cnt++;
         end
         stall_q = bus.valid_out & ~bus.ready_in;
         stall_d = bus.data_out;
         if (done) begin
            done_cnt++;
            check("done_gap", cyc - last_acc_cyc, 1);
            check("done_q_empty", q.size(), 0);
         end
         nbuf = nbuf + int'(prev_rd) - int'(bus.valid_out && bus.ready_in);
         prev_rd = bus.ram_read_en_out;
      end
   end

   // Monitor for the N=1 instance.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus1.valid_out && bus1.ready_in) begin
            check("q1_nonempty", q1.size() != 0, 1);
            if (q1.size() != 0) begin
               e = q1.pop_front();
               check("n1_data", bus1.data_out, e.d);
               check("n1_last", bus1.last_out, e.l);
            end
         end
         if (done1) begin
            done1_cnt++;
            check("n1_done_q_empty", q1.size(), 0);
         end
      end
   end

   task automatic fill_q();
      logic [31:0] v;
      for (int i = 0; i < N; i++) begin
         v = 32'(i);
         q.push_back('{d: {COLS{v}}, l: (i == N - 1)});
      end
      rd_idx  = 0;
      acc_cnt = 0;
   endtask

   task automatic pulse_start();
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0 = done_cnt;
      for (int c = 0; c < budget && done_cnt == d0; c++) @(negedge clk);
      check(name, done_cnt, d0 + 1);
   endtask

   task automatic wait_acc(input string name, input int n, input int budget);
      for (int c = 0; c < budget && acc_cnt < n; c++) @(negedge clk);
      check(name, acc_cnt >= n, 1);
   endtask

   logic [W-1:0] exp5, exp6;
   int d0;

   initial begin
      bus1.ready_in = 1'b1;
      pat1 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_valid", bus.valid_out, 0);
      check("rst_last", bus.last_out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_rden", bus.ram_read_en_out, 0);
      check("rst_addr", bus.ram_addr_out, 0);
      check("rst_data", bus.data_out, 0);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);

      // T1: full-rate streaming with start latency checks.
      rdy_mode = 1;
      fill_q();
      pulse_start();
      check("t1_busy_after_start", busy, 1);
      check("t1_rden_after_start", bus.ram_read_en_out, 1);
      @(posedge clk);
      #1 check("t1_no_valid_yet", bus.valid_out, 0);
      @(posedge clk);
      #1 check("t1_first_valid", bus.valid_out, 1);
      wait_done("t1_done", 3000);
      check("t1_count", acc_cnt, N);
      check("t1_back_to_back", last_acc_cyc - first_acc_cyc, N - 1);
      @(negedge clk);
      check("t1_busy_idle", busy, 0);

      // T2: random 30% ready.
      rdy_mode = 2;
      fill_q();
      pulse_start();
      wait_done("t2_done", 20000);
      check("t2_count", acc_cnt, N);

      // T3: second start mid-run is ignored.
      rdy_mode = 1;
      fill_q();
      pulse_start();
      wait_acc("t3_reach_100", 100, 3000);
      pulse_start();
      wait_done("t3_done", 3000);
      check("t3_count", acc_cnt, N);
      d0 = done_cnt;
      repeat (10) @(negedge clk);
      check("t3_single_done", done_cnt, d0);

      // T4: reset mid-run under back-pressure, then a fresh run.
      fill_q();
      pulse_start();
      wait_acc("t4_reach_300", 300, 3000);
      rdy_mode = 0;
      repeat (5) @(posedge clk);
      d0 = done_cnt;
      #1 rst = 1'b1;
      @(negedge clk);
      check("t4_valid", bus.valid_out, 0);
      check("t4_last", bus.last_out, 0);
      check("t4_busy", busy, 0);
      check("t4_done", done, 0);
      check("t4_rden", bus.ram_read_en_out, 0);
      check("t4_addr", bus.ram_addr_out, 0);
      check("t4_data", bus.data_out, 0);
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      check("t4_no_done", done_cnt, d0);
      rdy_mode = 1;
      fill_q();
      pulse_start();
      wait_done("t4_fresh_done", 3000);
      check("t4_fresh_count", acc_cnt, N);

      // T5: N=1, DEADBEEF in every lane.
      pat1 = {COLS{32'hDEADBEEF}};
`ifdef OUTPUT_READBACK_RELU_EN
      exp5 = '0;
`else
      exp5 = {COLS{32'hDEADBEEF}};
`endif
      q1.push_back('{d: exp5, l: 1'b1});
      d0 = done1_cnt;
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int c = 0; c < 50 && done1_cnt == d0; c++) @(negedge clk);
      check("t5_done", done1_cnt, d0 + 1);

      // T6: mixed-sign lanes.
      for (int k = 0; k < COLS; k++) begin
         pat1[k*BW +: BW] = (k % 2 == 0) ? 32'hFFFFFFFF : 32'h00000005;
`ifdef OUTPUT_READBACK_RELU_EN
         exp6[k*BW +: BW] = (k % 2 == 0) ? 32'h00000000 : 32'h00000005;
`else
         exp6[k*BW +: BW] = (k % 2 == 0) ? 32'hFFFFFFFF : 32'h00000005;
`endif
      end
      q1.push_back('{d: exp6, l: 1'b1});
      d0 = done1_cnt;
      @(posedge clk);
      #1 start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      for (int c = 0; c < 50 && done1_cnt == d0; c++) @(negedge clk);
      check("t6_done", done1_cnt, d0 + 1);
      check("t6_q1_empty", q1.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
